// File: rtl/gpio_pkg.sv
// Shared constants, types and helpers for the GPIO pad controller.
package gpio_pkg;

    localparam int GPIO_SYNC_MIN = 2;
    localparam int GPIO_SYNC_MAX = 4;
    // Counter is sized for the widest supported debounce limit.
    localparam int GPIO_CNT_W    = 16;

    typedef logic [GPIO_CNT_W-1:0] gpio_cnt_t;

    typedef struct packed {
        gpio_cnt_t cnt;
        logic      flt;
    } gpio_flt_t;

    // A debounce limit of zero behaves like a limit of one.
    function automatic gpio_cnt_t gpio_eff_limit(input gpio_cnt_t limit);
        if (limit == {GPIO_CNT_W{1'b0}}) begin
            return gpio_cnt_t'(1'b1);
        end else begin
            return limit;
        end
    endfunction

endpackage

// File: rtl/gpio_bit_filter.sv
// Per-pad input path: synchroniser, debounce filter and edge strobes.
module gpio_bit_filter
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      pad,
    input  logic      deb_en,
    input  gpio_cnt_t limit,
    output logic      flt,
    output logic      rise,
    output logic      fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   syn_s;
    gpio_flt_t              state_r;
    gpio_flt_t              next_s;
    gpio_cnt_t              cnt_inc_s;

    assign syn_s     = sync_r[SYNC_STAGES-1];
    assign cnt_inc_s = state_r.cnt + gpio_cnt_t'(1'b1);

    // Synchroniser shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pad};
        end
    end

    // Next filter state; the >= compare lets a lowered limit finish at once.
    always_comb begin
        next_s = state_r;
        if (!deb_en) begin
            next_s.flt = syn_s;
            next_s.cnt = {GPIO_CNT_W{1'b0}};
        end else if (syn_s == state_r.flt) begin
            next_s.cnt = {GPIO_CNT_W{1'b0}};
        end else if (cnt_inc_s >= limit) begin
            next_s.flt = syn_s;
            next_s.cnt = {GPIO_CNT_W{1'b0}};
        end else if (cnt_inc_s != {GPIO_CNT_W{1'b0}}) begin
            next_s.cnt = cnt_inc_s;
        end else begin
            next_s.cnt = state_r.cnt;
        end
    end

    // Filter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= '{cnt: {GPIO_CNT_W{1'b0}}, flt: 1'b0};
        end else begin
            state_r <= next_s;
        end
    end

    assign flt  = state_r.flt;
    assign rise =  next_s.flt & ~state_r.flt;
    assign fall = ~next_s.flt &  state_r.flt;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Bidirectional GPIO pad controller with filtered inputs and sticky edge interrupts.
module gpio_pad_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [WIDTH-1:0] out_data,
    input  logic [WIDTH-1:0] out_en,
    input  logic [WIDTH-1:0] deb_en,
    input  logic [DEB_W-1:0] deb_limit,
    input  logic [WIDTH-1:0] irq_rise_en,
    input  logic [WIDTH-1:0] irq_fall_en,
    input  logic [WIDTH-1:0] irq_clr,
    inout  wire  [WIDTH-1:0] io_pad,
    output logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq
);

    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 2);

    if (SYNC_STAGES < GPIO_SYNC_MIN || SYNC_STAGES > GPIO_SYNC_MAX ||
        DEB_W > GPIO_CNT_W) begin : g_bad_param
        $error("gpio_pad_ctrl: SYNC_STAGES or DEB_W out of range");
    end

    gpio_cnt_t        limit_s;
    logic [WIDTH-1:0] flt_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] status_next_s;
    logic [2:0]       warm_r;
    logic             armed_s;

    assign limit_s = gpio_eff_limit(gpio_cnt_t'(deb_limit));
    assign in_data = flt_s;
    assign armed_s = (warm_r == WARM_DONE);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // A driving pad reads back its own value through the same net.
        assign io_pad[i] = out_en[i] ? out_data[i] : 1'bz;

        gpio_bit_filter #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_filt (
            .clk    (HCLK),
            .rst_n  (HRESETn),
            .pad    (io_pad[i]),
            .deb_en (deb_en[i]),
            .limit  (limit_s),
            .flt    (flt_s[i]),
            .rise   (rise_s[i]),
            .fall   (fall_s[i])
        );
    end

    // Warm-up counter keeps edge detection off until the filters hold real pad data.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            warm_r <= 3'd0;
        end else if (warm_r != WARM_DONE) begin
            warm_r <= warm_r + 3'd1;
        end else begin
            warm_r <= warm_r;
        end
    end

    // Sticky status: a new edge wins over a simultaneous clear.
    always_comb begin
        status_next_s = irq_status & ~irq_clr;
        if (armed_s) begin
            status_next_s = status_next_s | (rise_s & irq_rise_en) | (fall_s & irq_fall_en);
        end else begin
            status_next_s = status_next_s;
        end
    end

    // Status and combined interrupt registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_status <= {WIDTH{1'b0}};
            irq        <= 1'b0;
        end else begin
            irq_status <= status_next_s;
            irq        <= |irq_status;
        end
    end

endmodule
